// File: rtl/dram_pkg.sv
// Shared DRAM command-bus definitions: command decode, FSM states and default
// geometry with its derived widths, for use by both the controller and this device.
package dram_pkg;

  localparam int DEF_NUMBER_OF_COLUMNS = 8;
  localparam int DEF_NUMBER_OF_ROWS    = 128;
  localparam int DEF_NUMBER_OF_BANKS   = 8;
  localparam int DEF_DRAM_DATA_WIDTH   = 2;

  localparam int DEF_COLUMN_WIDTH    = $clog2(DEF_NUMBER_OF_COLUMNS / DEF_DRAM_DATA_WIDTH);
  localparam int DEF_ROW_WIDTH       = $clog2(DEF_NUMBER_OF_ROWS);
  localparam int DEF_BANK_ID_WIDTH   = $clog2(DEF_NUMBER_OF_BANKS);
  localparam int DEF_DRAM_ADDR_WIDTH = (DEF_ROW_WIDTH > DEF_COLUMN_WIDTH) ?
                                       DEF_ROW_WIDTH : DEF_COLUMN_WIDTH;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_READ,
    CMD_WRITE,
    CMD_PRE,
    CMD_REF,
    CMD_ILLEGAL
  } dram_cmd_e;

  typedef enum logic {
    ST_IDLE,
    ST_REFRESH
  } dram_state_e;

  function automatic dram_cmd_e dram_decode(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
    dram_cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b111:         c = CMD_NOP;
        3'b011:         c = CMD_ACT;
        3'b101:         c = CMD_READ;
        3'b100:         c = CMD_WRITE;
        3'b010:         c = CMD_PRE;
        3'b001:         c = CMD_REF;
        3'b000, 3'b110: c = CMD_ILLEGAL;
        default:        c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_storage_array.sv
// Word-addressed DRAM storage: synchronous write, registered read that holds its
// value until the next read. Contents are deliberately not reset.
module dram_storage_array #(
  parameter int DATA_WIDTH = 2,
  parameter int INDEX_WIDTH = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic                   i_rd_en,
  input  logic [INDEX_WIDTH-1:0] i_index,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  output logic [DATA_WIDTH-1:0]  o_rd_data
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_index] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_index];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dram_device_model.sv
// Single-rank DRAM responder: decodes the command bus, tracks one open row per
// bank, runs the refresh FSM and flags protocol violations on err_cmd.
module dram_device_model
  import dram_pkg::*;
#(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 2,
  parameter int REFRESH_CYCLES    = 4,
  localparam int COLUMN_WIDTH     = $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH),
  localparam int ROW_WIDTH        = $clog2(NUMBER_OF_ROWS),
  localparam int BANK_ID_WIDTH    = $clog2(NUMBER_OF_BANKS),
  localparam int DRAM_ADDR_WIDTH  = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
  input  logic                       u_clk,
  input  logic                       u_rst,
  input  logic                       dram_clk_en,
  input  logic                       dram_cs_n,
  input  logic                       dram_ras_n,
  input  logic                       dram_cas_n,
  input  logic                       dram_we_n,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
  output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
  output logic                       dram_refresh_done,
  output logic [NUMBER_OF_BANKS-1:0] bank_open,
  output logic                       err_cmd
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IDX_W = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;

  dram_state_e                r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [NUMBER_OF_BANKS-1:0] r_bank_open, w_bank_open_nxt;
  logic                       r_err, w_err;
  logic [ROW_WIDTH-1:0]       r_open_row [NUMBER_OF_BANKS];

  dram_cmd_e                  w_cmd;
  logic [ROW_WIDTH-1:0]       w_row;
  logic [COLUMN_WIDTH-1:0]    w_col;
  logic                       w_sel_open;
  logic                       w_done;
  logic                       w_act, w_rd_en, w_wr_en;

  assign w_cmd      = dram_decode(dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n);
  assign w_row      = dram_addr[ROW_WIDTH-1:0];
  assign w_col      = dram_addr[COLUMN_WIDTH-1:0];
  assign w_sel_open = r_bank_open[dram_bank_id];
  assign w_done     = (r_state == ST_REFRESH) && (r_cnt == '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bank_open_nxt = r_bank_open;
    w_err           = 1'b0;
    w_act           = 1'b0;
    w_rd_en         = 1'b0;
    w_wr_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (w_cmd)
          CMD_ACT: begin
            if (w_sel_open) begin
              w_err = 1'b1;
            end else begin
              w_act                         = 1'b1;
              w_bank_open_nxt[dram_bank_id] = 1'b1;
            end
          end
          CMD_READ: begin
            w_rd_en = w_sel_open;
            w_err   = !w_sel_open;
          end
          CMD_WRITE: begin
            w_wr_en = w_sel_open;
            w_err   = !w_sel_open;
          end
          CMD_PRE: begin
            w_bank_open_nxt[dram_bank_id] = 1'b0;
            w_err = w_sel_open && (r_open_row[dram_bank_id] != w_row);
          end
          CMD_REF: begin
            w_bank_open_nxt = '0;
            w_state_nxt     = ST_REFRESH;
            w_cnt_nxt       = CNT_W'(REFRESH_CYCLES - 1);
          end
          CMD_ILLEGAL: w_err = 1'b1;
          default: ;
        endcase
      end
      ST_REFRESH: begin
        // REF is silently absorbed here, so a REF on the done cycle cannot re-arm
        if (w_done) w_state_nxt = ST_IDLE;
        else        w_cnt_nxt   = r_cnt - 1'b1;
        case (w_cmd)
          CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_ILLEGAL: w_err = 1'b1;
          default: ;
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge u_clk or posedge u_rst) begin
    if (u_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bank_open <= '0;
      r_err       <= 1'b0;
    end else if (dram_clk_en) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bank_open <= w_bank_open_nxt;
      r_err       <= w_err;
    end
  end

  always_ff @(posedge u_clk) begin
    if (dram_clk_en && w_act) r_open_row[dram_bank_id] <= w_row;
  end

  dram_storage_array #(
    .DATA_WIDTH (DRAM_DATA_WIDTH),
    .INDEX_WIDTH(IDX_W)
  ) u_storage (
    .i_clk    (u_clk),
    .i_rst    (u_rst),
    .i_wr_en  (dram_clk_en && w_wr_en),
    .i_rd_en  (dram_clk_en && w_rd_en),
    .i_index  ({dram_bank_id, r_open_row[dram_bank_id], w_col}),
    .i_wr_data(dram_wr_data),
    .o_rd_data(dram_rd_data)
  );

  assign dram_refresh_done = w_done;
  assign bank_open         = r_bank_open;
  assign err_cmd           = r_err;

endmodule

// File: tb/tb_dram_device_model.sv
// Directed bench for dram_device_model: row tracking, read/write, errors,
// refresh timing, clock-enable freeze and asynchronous reset.
module tb_dram_device_model;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_IL0 = 4'b0000;
  localparam logic [3:0] C_IL6 = 4'b0110;

  logic       u_clk = 1'b0;
  logic       u_rst;
  logic       dram_clk_en;
  logic       dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
  logic [6:0] dram_addr;
  logic [2:0] dram_bank_id;
  logic [1:0] dram_wr_data;
  logic [1:0] dram_rd_data;
  logic       dram_refresh_done;
  logic [7:0] bank_open;
  logic       err_cmd;

  int n_total = 0;
  int n_pass  = 0;

  dram_device_model #(
    .NUMBER_OF_COLUMNS(8),
    .NUMBER_OF_ROWS   (128),
    .NUMBER_OF_BANKS  (8),
    .DRAM_DATA_WIDTH  (2),
    .REFRESH_CYCLES   (4)
  ) dut (
    .u_clk            (u_clk),
    .u_rst            (u_rst),
    .dram_clk_en      (dram_clk_en),
    .dram_cs_n        (dram_cs_n),
    .dram_ras_n       (dram_ras_n),
    .dram_cas_n       (dram_cas_n),
    .dram_we_n        (dram_we_n),
    .dram_addr        (dram_addr),
    .dram_bank_id     (dram_bank_id),
    .dram_wr_data     (dram_wr_data),
    .dram_rd_data     (dram_rd_data),
    .dram_refresh_done(dram_refresh_done),
    .bank_open        (bank_open),
    .err_cmd          (err_cmd)
  );

  always #5 u_clk = ~u_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command, let one rising edge sample it, then settle 1 time unit.
  task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [6:0] a,
                       input logic [1:0] d);
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = c;
    dram_bank_id = b;
    dram_addr    = a;
    dram_wr_data = d;
    @(posedge u_clk);
    #1;
  endtask

  initial begin
    u_rst       = 1'b1;
    dram_clk_en = 1'b1;
    {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = C_NOP;
    dram_addr    = '0;
    dram_bank_id = '0;
    dram_wr_data = '0;
    @(posedge u_clk); @(posedge u_clk); #1;
    check("rst_rd_data", dram_rd_data, 2'b00);
    check("rst_done", dram_refresh_done, 1'b0);
    check("rst_err", err_cmd, 1'b0);
    check("rst_bank_open", bank_open, 8'h00);
    u_rst = 1'b0;

    // Basic write/read through an opened row
    issue(C_ACT, 3'd2, 7'd5, 2'b00);
    check("act_b2_open", bank_open, 8'h04);
    check("act_b2_err", err_cmd, 1'b0);
    issue(C_WR, 3'd2, 7'd1, 2'b10);
    check("wr_b2c1_err", err_cmd, 1'b0);
    issue(C_WR, 3'd2, 7'd2, 2'b01);
    issue(C_RD, 3'd2, 7'd1, 2'b00);
    check("rd_b2c1", dram_rd_data, 2'b10);
    check("rd_b2c1_err", err_cmd, 1'b0);
    issue(C_RD, 3'd2, 7'd2, 2'b00);
    check("rd_b2c2", dram_rd_data, 2'b01);
    issue(C_RD, 3'd2, 7'b1010001, 2'b00);
    check("rd_upper_addr_ignored", dram_rd_data, 2'b10);

    // Read of a closed bank
    issue(C_RD, 3'd3, 7'd1, 2'b00);
    check("rd_closed_err", err_cmd, 1'b1);
    check("rd_closed_data_held", dram_rd_data, 2'b10);
    check("rd_closed_open", bank_open, 8'h04);
    issue(C_NOP, 3'd0, 7'd0, 2'b00);
    check("rd_closed_err_1cyc", err_cmd, 1'b0);
    check("nop_data_held", dram_rd_data, 2'b10);

    // Write then read at the next edge
    issue(C_WR, 3'd2, 7'd3, 2'b11);
    issue(C_RD, 3'd2, 7'd3, 2'b00);
    check("wr_then_rd", dram_rd_data, 2'b11);

    // Illegal encodings
    issue(C_IL0, 3'd2, 7'd0, 2'b00);
    check("ill0000_err", err_cmd, 1'b1);
    check("ill0000_open", bank_open, 8'h04);
    issue(C_IL6, 3'd2, 7'd0, 2'b00);
    check("ill0110_err", err_cmd, 1'b1);
    check("ill0110_data", dram_rd_data, 2'b11);

    // Double ACT keeps the original row
    issue(C_ACT, 3'd1, 7'd9, 2'b00);
    check("act_b1_open", bank_open, 8'h06);
    check("act_b1_err", err_cmd, 1'b0);
    issue(C_ACT, 3'd1, 7'd3, 2'b00);
    check("act_twice_err", err_cmd, 1'b1);
    check("act_twice_open", bank_open, 8'h06);
    issue(C_PRE, 3'd1, 7'd9, 2'b00);
    check("pre_match_err", err_cmd, 1'b0);
    check("pre_match_open", bank_open, 8'h04);
    issue(C_ACT, 3'd1, 7'd9, 2'b00);
    issue(C_PRE, 3'd1, 7'd4, 2'b00);
    check("pre_mismatch_err", err_cmd, 1'b1);
    check("pre_mismatch_closed", bank_open, 8'h04);
    issue(C_PRE, 3'd1, 7'd0, 2'b00);
    check("pre_closed_err", err_cmd, 1'b0);
    check("pre_closed_open", bank_open, 8'h04);

    // Refresh with REF held through the done cycle
    issue(C_ACT, 3'd0, 7'd1, 2'b00);
    issue(C_ACT, 3'd7, 7'd2, 2'b00);
    check("pre_ref_open", bank_open, 8'h85);
    issue(C_REF, 3'd0, 7'd0, 2'b00);
    check("ref_closes_all", bank_open, 8'h00);
    check("ref_err", err_cmd, 1'b0);
    check("ref_done_c1", dram_refresh_done, 1'b0);
    issue(C_REF, 3'd0, 7'd0, 2'b00);
    check("ref_done_c2", dram_refresh_done, 1'b0);
    issue(C_REF, 3'd0, 7'd0, 2'b00);
    check("ref_done_c3", dram_refresh_done, 1'b0);
    issue(C_REF, 3'd0, 7'd0, 2'b00);
    check("ref_done_c4", dram_refresh_done, 1'b1);
    check("ref_in_refresh_err", err_cmd, 1'b0);
    issue(C_REF, 3'd0, 7'd0, 2'b00);
    check("ref_done_c5", dram_refresh_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      issue(C_NOP, 3'd0, 7'd0, 2'b00);
      check($sformatf("no_rerefresh_%0d", i), dram_refresh_done, 1'b0);
    end
    issue(C_ACT, 3'd3, 7'd1, 2'b00);
    check("post_ref_act", bank_open, 8'h08);
    issue(C_PRE, 3'd3, 7'd1, 2'b00);

    // Clock-enable freeze during refresh
    issue(C_REF, 3'd0, 7'd0, 2'b00);
    issue(C_NOP, 3'd0, 7'd0, 2'b00);
    dram_clk_en = 1'b0;
    issue(C_ACT, 3'd5, 7'd1, 2'b00);
    check("dis_act_open", bank_open, 8'h00);
    check("dis_act_err", err_cmd, 1'b0);
    issue(C_IL0, 3'd5, 7'd1, 2'b00);
    check("dis_ill_err", err_cmd, 1'b0);
    issue(C_REF, 3'd5, 7'd1, 2'b00);
    check("dis_done", dram_refresh_done, 1'b0);
    dram_clk_en = 1'b1;
    issue(C_NOP, 3'd0, 7'd0, 2'b00);
    check("en_done_c3", dram_refresh_done, 1'b0);
    issue(C_ACT, 3'd6, 7'd1, 2'b00);
    check("refresh_act_err", err_cmd, 1'b1);
    check("refresh_act_open", bank_open, 8'h00);
    check("en_done_late", dram_refresh_done, 1'b1);
    dram_clk_en = 1'b0;
    issue(C_NOP, 3'd0, 7'd0, 2'b00);
    issue(C_NOP, 3'd0, 7'd0, 2'b00);
    check("done_stretched", dram_refresh_done, 1'b1);
    check("err_held", err_cmd, 1'b1);
    dram_clk_en = 1'b1;
    issue(C_NOP, 3'd0, 7'd0, 2'b00);
    check("done_released", dram_refresh_done, 1'b0);
    check("err_released", err_cmd, 1'b0);

    // Asynchronous reset mid-refresh
    issue(C_ACT, 3'd2, 7'd5, 2'b00);
    issue(C_RD, 3'd2, 7'd3, 2'b00);
    check("pre_rst_rd", dram_rd_data, 2'b11);
    issue(C_PRE, 3'd2, 7'd5, 2'b00);
    issue(C_REF, 3'd0, 7'd0, 2'b00);
    issue(C_NOP, 3'd0, 7'd0, 2'b00);
    #2;
    u_rst = 1'b1;
    #1;
    check("async_rst_rd", dram_rd_data, 2'b00);
    check("async_rst_done", dram_refresh_done, 1'b0);
    check("async_rst_err", err_cmd, 1'b0);
    check("async_rst_open", bank_open, 8'h00);
    @(posedge u_clk); #1;
    u_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(C_NOP, 3'd0, 7'd0, 2'b00);
      check($sformatf("no_done_after_rst_%0d", i), dram_refresh_done, 1'b0);
    end
    issue(C_ACT, 3'd2, 7'd5, 2'b00);
    issue(C_RD, 3'd2, 7'd1, 2'b00);
    check("mem_kept_c1", dram_rd_data, 2'b10);
    issue(C_RD, 3'd2, 7'd3, 2'b00);
    check("mem_kept_c3", dram_rd_data, 2'b11);
    check("mem_kept_err", err_cmd, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dram_device_model.md
# dram_device_model

Synthesizable single-rank DRAM responder for the far end of the controller's DRAM command interface. It decodes the cs/ras/cas/we command bus and tracks one open row per bank. It stores write data, returns read data one cycle after a READ, and executes REFRESH with a one-cycle `dram_refresh_done` pulse. It serves as the memory for controller-level simulation and FPGA loopback tests.

## Interface
- `NUMBER_OF_COLUMNS`, 8: columns per row, in bits.
- `NUMBER_OF_ROWS`, 128: rows per bank.
- `NUMBER_OF_BANKS`, 8: bank count.
- `DRAM_DATA_WIDTH`, 2: data word width.
- `REFRESH_CYCLES`, 4: cycles from REFRESH start to the `dram_refresh_done` pulse, ≥1.
- Derived, never overridden:
  - `COLUMN_WIDTH` = clog2(NUMBER_OF_COLUMNS/DRAM_DATA_WIDTH)
  - `ROW_WIDTH` = clog2(NUMBER_OF_ROWS)
  - `BANK_ID_WIDTH` = clog2(NUMBER_OF_BANKS)
  - `DRAM_ADDR_WIDTH` = max(ROW_WIDTH, COLUMN_WIDTH)

Ports:
- `u_clk`  in  1  sole clock, rising edge.
- `u_rst`  in  1  reset, asynchronous, active-high.
- `dram_clk_en`  in  1  when 0, all state freezes and commands are ignored.
- `dram_cs_n`, `dram_ras_n`, `dram_cas_n`, `dram_we_n`  in  1 each  command bus.
- `dram_addr`  in  DRAM_ADDR_WIDTH  row address (ACT/PRE), or column address in the low COLUMN_WIDTH bits (READ/WRITE).
- `dram_bank_id`  in  BANK_ID_WIDTH  target bank.
- `dram_wr_data`  in  DRAM_DATA_WIDTH  write data.
- `dram_rd_data`  out  DRAM_DATA_WIDTH  registered read data.
- `dram_refresh_done`  out  1  one-cycle pulse at the end of a refresh.
- `bank_open`  out  NUMBER_OF_BANKS  per-bank open-row flags.
- `err_cmd`  out  1  one-cycle pulse on a protocol violation.

## Operation
- A command is sampled on the rising edge only when `dram_clk_en`=1.
- Encoding {cs_n, ras_n, cas_n, we_n}:
  - cs_n=1 or 0111: NOP.
  - 0011: ACT.
  - 0101: READ.
  - 0100: WRITE.
  - 0010: PRE.
  - 0001: REF.
  - 0000 and 0110: illegal; `err_cmd` pulses and nothing else changes.
- Per bank b the block holds `bank_open[b]` and `open_row[b]`.
- ACT to a closed bank: open_row ← addr[ROW_WIDTH-1:0], bank_open ← 1.
- ACT to an open bank: `err_cmd` pulses, state is unchanged.
- READ to an open bank: `dram_rd_data` ← mem[bank][open_row][col]. The output holds that value until the next READ.
- WRITE to an open bank: mem[bank][open_row][col] ← `dram_wr_data`.
- READ or WRITE to a closed bank: `err_cmd` pulses, no memory access, `dram_rd_data` is unchanged.
- PRE: closes the addressed bank.
  - PRE to a closed bank is a legal no-op.
  - PRE to an open bank whose open_row ≠ addr row: the bank still closes and `err_cmd` pulses.
- REF in state IDLE: closes all banks (implicit precharge-all, not an error) and enters REFRESH.
- State machine, 2 states:
  - IDLE → REFRESH on REF; refresh counter ← REFRESH_CYCLES-1.
  - REFRESH: the counter decrements each enabled cycle. On the cycle the counter is 0, `dram_refresh_done`=1 and the next state is IDLE.
  - In REFRESH, REF commands are ignored without error, including the REF sampled on the done cycle, which must not restart a refresh.
  - In REFRESH, NOP is legal. ACT, READ, WRITE and PRE are ignored and pulse `err_cmd`.
- Memory contents are not cleared by reset.
- Column index = addr[COLUMN_WIDTH-1:0]. Upper address bits are ignored.

## Timing
- Reset values: `dram_rd_data`=0, `dram_refresh_done`=0, `err_cmd`=0, `bank_open`=0, state IDLE, counter 0.
- Reset asserted mid-refresh aborts it; no done pulse follows.
- READ latency is 1 cycle: data for a READ sampled at edge N is valid from just after edge N. The controller samples it at edge N+1.
- WRITE then READ of the same location at the next edge returns the new data.
- Refresh: REF sampled at edge N puts done high in the cycle after edge N+REFRESH_CYCLES-1. With REFRESH_CYCLES=1, done is high in the cycle right after edge N.
- `bank_open` updates at the command edge and is registered.
- `dram_clk_en`=0 holds the counter, the outputs and the done pulse: a pending done pulse stretches until enable returns.

## Structure
- Shared package `dram_pkg` holds:
  - the command enum (NOP, ACT, READ, WRITE, PRE, REF, ILLEGAL);
  - a decode function from {cs_n, ras_n, cas_n, we_n};
  - the derived-width helper constants, shared with the controller.
- Sub-module `dram_storage_array`: NUMBER_OF_BANKS·NUMBER_OF_ROWS·(COLS/DW) words of DW bits, synchronous write, synchronous registered read, flat index {bank,row,col}.
- Top level holds the command decode, the per-bank row tracking, the refresh FSM/counter and error generation.

## Test plan
- ACT bank2 row5, WRITE col1 data 2'b10, READ col1 → `dram_rd_data`=2'b10 after the READ edge, `err_cmd` never high.
- READ bank3 while closed → `err_cmd` pulse for 1 cycle, `dram_rd_data` unchanged, `bank_open` unchanged.
- Open banks 0 and 7, then REF held for 6 cycles (REFRESH_CYCLES=4) → `bank_open`=0 after the first edge, done high exactly once on the 4th cycle after the REF edge, no second refresh.
- ACT bank1 row9 twice → second ACT pulses `err_cmd`, open_row stays 9. PRE bank1 addr 9 → bank closed, no error.
- `dram_clk_en`=0 for 3 cycles during refresh → done is delayed by 3 cycles, and commands issued while disabled have no effect.
- Assert `u_rst` mid-refresh → all outputs 0 immediately (asynchronous), no done pulse. Data written before reset is readable after a new ACT.
